// File: rtl/player_pkg.sv
`default_nettype none
// ============================================================================
// Module      : player_pkg
// Description : Shared definitions for the grid player mover. Holds the
//               direction encoding, the movement FSM state encoding, the
//               screen/sprite geometry defaults shared with the renderer and
//               the fixed-priority direction arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package player_pkg;

    // Geometry defaults, also used by the renderer
    localparam int c_H_DISPLAY = 640;
    localparam int c_V_DISPLAY = 480;
    localparam int c_TILE      = 32;
    localparam int c_PLAYER_W  = 32;
    localparam int c_PLAYER_H  = 32;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_REPEAT    = 2'd2,
        ST_LOCKOUT   = 2'd3
    } state_e;

    // Fixed priority up > down > left > right; bit 0 = up ... bit 3 = right.
    // Returns DIR_RIGHT when nothing is pressed; callers qualify with "any".
    function automatic dir_e arbitrate(input logic [3:0] sw);
        dir_e d;
        if (sw[0])      d = DIR_UP;
        else if (sw[1]) d = DIR_DOWN;
        else if (sw[2]) d = DIR_LEFT;
        else            d = DIR_RIGHT;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : 2-FF synchroniser followed by a stability counter. The output
//               level follows the synchronised input only after it has held
//               the new level for DEBOUNCE_CYCLES consecutive cycles.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               i_raw   - raw asynchronous switch input
//               o_level - debounced level (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            // Any cycle back at the accepted level restarts the stability count
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/grid_player_mover.sv
`default_nettype none
// ============================================================================
// Module      : grid_player_mover
// Description : Tile-stepped player position controller. Debounces the four
//               direction switches, arbitrates to one direction, steps the
//               sprite one TILE per press (optionally with hold-to-repeat),
//               refuses steps that would leave the screen, and supports
//               respawn and freeze requests.
// Ports       : CLK, RST_N (async active-low), SW1..SW4 (up/down/left/right),
//               i_respawn, i_freeze, o_player_x/o_player_y (sprite top-left),
//               o_moved/o_blocked (one-cycle pulses), o_dir (last direction)
// Config      : PLAYER_AUTOREPEAT_EN - build HOLD_WAIT/REPEAT and timers;
//               when undefined every press gives exactly one step.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_player_mover
    import player_pkg::*;
#(
    parameter int H_DISPLAY       = c_H_DISPLAY,
    parameter int V_DISPLAY       = c_V_DISPLAY,
    parameter int TILE            = c_TILE,
    parameter int PLAYER_W        = c_PLAYER_W,
    parameter int PLAYER_H        = c_PLAYER_H,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_DELAY      = 6250000,
    parameter int REPEAT_PERIOD   = 3125000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    input  logic       SW4,
    input  logic       i_respawn,
    input  logic       i_freeze,
    output logic [9:0] o_player_x,
    output logic [9:0] o_player_y,
    output logic       o_moved,
    output logic       o_blocked,
    output logic [1:0] o_dir
);

    localparam logic [9:0]  c_SPAWN_X = 10'(H_DISPLAY / 2 - PLAYER_W / 2);
    localparam logic [9:0]  c_SPAWN_Y = 10'(V_DISPLAY - PLAYER_H);
    localparam logic [9:0]  c_TILE10  = 10'(TILE);
    localparam logic [10:0] c_TILE11  = 11'(TILE);
    localparam logic [10:0] c_X_MAX   = 11'(H_DISPLAY - PLAYER_W);
    localparam logic [10:0] c_Y_MAX   = 11'(V_DISPLAY - PLAYER_H);

    if (HOLD_DELAY < 1 || REPEAT_PERIOD < 1 || DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("grid_player_mover: timing parameters must be at least 1");
    end

    // Reset: asserts asynchronously, releases two clocks after RST_N rises
    logic r_rst_meta;
    logic r_rst_sync;
    logic w_rst_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    // Switch conditioning; bit 0 = up ... bit 3 = right
    logic [3:0] w_raw;
    logic [3:0] w_deb;

    assign w_raw = {SW4, SW3, SW2, SW1};

    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (CLK),
            .rst_n   (w_rst_n),
            .i_raw   (w_raw[gi]),
            .o_level (w_deb[gi])
        );
    end

    logic w_any;
    dir_e w_arb;

    assign w_any = |w_deb;
    assign w_arb = arbitrate(w_deb);

    state_e     r_state, w_state_nxt;
    logic [9:0] r_x, r_y, w_x_nxt, w_y_nxt;
    dir_e       r_dir, w_dir_nxt;
    logic       r_moved, r_blocked, w_moved_nxt, w_blocked_nxt;
    logic       w_step;
    logic       w_legal;

`ifdef PLAYER_AUTOREPEAT_EN
    localparam int TMR_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] c_HOLD_LAST = TMR_W'(HOLD_DELAY - 1);
    localparam logic [TMR_W-1:0] c_REP_LAST  = TMR_W'(REPEAT_PERIOD - 1);

    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
`endif

    // Next state; a direction change while held is treated as a fresh press
    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
`ifdef PLAYER_AUTOREPEAT_EN
        w_tmr_nxt   = '0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_step = 1'b1;
`ifdef PLAYER_AUTOREPEAT_EN
                    w_state_nxt = ST_HOLD_WAIT;
`else
                    w_state_nxt = ST_LOCKOUT;
`endif
                end
            end
`ifdef PLAYER_AUTOREPEAT_EN
            ST_HOLD_WAIT, ST_REPEAT: begin
                if (!w_any) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_arb != r_dir) begin
                    w_step      = 1'b1;
                    w_state_nxt = ST_HOLD_WAIT;
                end else if (r_tmr == ((r_state == ST_HOLD_WAIT) ? c_HOLD_LAST : c_REP_LAST)) begin
                    w_step      = 1'b1;
                    w_state_nxt = ST_REPEAT;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
`endif
            ST_LOCKOUT: begin
                if (!w_any) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (i_freeze || i_respawn) begin
            w_step      = 1'b0;
            w_state_nxt = ST_LOCKOUT;
`ifdef PLAYER_AUTOREPEAT_EN
            w_tmr_nxt   = '0;
`endif
        end
    end

    // Edge legality in 11 bits so x/y + TILE cannot wrap
    always_comb begin
        w_legal = 1'b0;
        case (w_arb)
            DIR_UP:    w_legal = {1'b0, r_y} >= c_TILE11;
            DIR_DOWN:  w_legal = ({1'b0, r_y} + c_TILE11) <= c_Y_MAX;
            DIR_LEFT:  w_legal = {1'b0, r_x} >= c_TILE11;
            DIR_RIGHT: w_legal = ({1'b0, r_x} + c_TILE11) <= c_X_MAX;
            default:   w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_dir_nxt     = r_dir;
        w_moved_nxt   = 1'b0;
        w_blocked_nxt = 1'b0;
        if (i_respawn) begin
            w_x_nxt = c_SPAWN_X;
            w_y_nxt = c_SPAWN_Y;
        end else if (w_step) begin
            w_dir_nxt = w_arb;
            if (w_legal) begin
                w_moved_nxt = 1'b1;
                case (w_arb)
                    DIR_UP:    w_y_nxt = r_y - c_TILE10;
                    DIR_DOWN:  w_y_nxt = r_y + c_TILE10;
                    DIR_LEFT:  w_x_nxt = r_x - c_TILE10;
                    default:   w_x_nxt = r_x + c_TILE10;
                endcase
            end else begin
                w_blocked_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_IDLE;
            r_x       <= c_SPAWN_X;
            r_y       <= c_SPAWN_Y;
            r_dir     <= DIR_UP;
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
`ifdef PLAYER_AUTOREPEAT_EN
            r_tmr     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_dir     <= w_dir_nxt;
            r_moved   <= w_moved_nxt;
            r_blocked <= w_blocked_nxt;
`ifdef PLAYER_AUTOREPEAT_EN
            r_tmr     <= w_tmr_nxt;
`endif
        end
    end

    assign o_player_x = r_x;
    assign o_player_y = r_y;
    assign o_moved    = r_moved;
    assign o_blocked  = r_blocked;
    assign o_dir      = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_grid_player_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_player_mover
// Description : Self-checking bench for grid_player_mover. Directed scenarios
//               followed by randomized switch/respawn/freeze traffic, all
//               compared every clock against a behavioural reference model.
//               Honours PLAYER_AUTOREPEAT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_player_mover;

    localparam int D    = 4;
    localparam int HOLD = 10;
    localparam int REP  = 5;
`ifdef PLAYER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       SW1 = 1'b0, SW2 = 1'b0, SW3 = 1'b0, SW4 = 1'b0;
    logic       i_respawn = 1'b0;
    logic       i_freeze = 1'b0;
    logic [9:0] o_player_x, o_player_y;
    logic       o_moved, o_blocked;
    logic [1:0] o_dir;

    grid_player_mover #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_DELAY      (HOLD),
        .REPEAT_PERIOD   (REP)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SW1        (SW1),
        .SW2        (SW2),
        .SW3        (SW3),
        .SW4        (SW4),
        .i_respawn  (i_respawn),
        .i_freeze   (i_freeze),
        .o_player_x (o_player_x),
        .o_player_y (o_player_y),
        .o_moved    (o_moved),
        .o_blocked  (o_blocked),
        .o_dir      (o_dir)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int n_moves_seen = 0;
    int n_blocks_seen = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Switch history as shift words: bit 0 is the newest sample.
    bit [31:0] raw_h[4];
    bit [31:0] dly_h[4];
    bit        m_deb[4];
    int        m_x, m_y, m_dir;
    bit        m_moved, m_blk;
    bit        m_locked, m_active;
    int        m_due, cyc;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            raw_h[i] = '0; dly_h[i] = '0; m_deb[i] = 1'b0;
        end
        m_x = 304; m_y = 448; m_dir = 0;
        m_moved = 0; m_blk = 0; m_locked = 0; m_active = 0; m_due = 0;
    endtask

    task automatic attempt(input int d);
        bit ok;
        m_dir = d;
        case (d)
            0: ok = (m_y >= 32);
            1: ok = (m_y + 32 <= 448);
            2: ok = (m_x >= 32);
            default: ok = (m_x + 32 <= 608);
        endcase
        if (ok) begin
            m_moved = 1;
            case (d)
                0: m_y -= 32;
                1: m_y += 32;
                2: m_x -= 32;
                default: m_x += 32;
            endcase
        end else begin
            m_blk = 1;
        end
    endtask

    task automatic model_edge(input logic [3:0] sw, input logic resp, input logic frz);
        bit any;
        int arb;
        bit diff;
        cyc++;
        any = 0; arb = 3;
        for (int i = 3; i >= 0; i--) if (m_deb[i]) begin any = 1; arb = i; end
        m_moved = 0; m_blk = 0;
        if (resp) begin
            m_x = 304; m_y = 448; m_locked = 1; m_active = 0;
        end else if (frz) begin
            m_locked = 1; m_active = 0;
        end else if (m_locked) begin
            if (!any) m_locked = 0;
        end else if (!any) begin
            m_active = 0;
        end else if (!m_active || arb != m_dir) begin
            attempt(arb);
            if (AR) begin m_active = 1; m_due = cyc + HOLD; end
            else m_locked = 1;
        end else if (cyc == m_due) begin
            attempt(arb);
            m_due = cyc + REP;
        end
        // Debounced level flips once the twice-delayed input has disagreed
        // with it for D edges in a row.
        for (int i = 0; i < 4; i++) begin
            raw_h[i] = {raw_h[i][30:0], sw[i]};
            dly_h[i] = {dly_h[i][30:0], raw_h[i][2]};
            diff = 1;
            for (int k = 0; k < D; k++) if (dly_h[i][k] == m_deb[i]) diff = 0;
            if (diff) m_deb[i] = ~m_deb[i];
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic tick(input logic [3:0] sw, input logic resp, input logic frz);
        {SW4, SW3, SW2, SW1} = sw;
        i_respawn = resp;
        i_freeze  = frz;
        @(posedge CLK);
        model_edge(sw, resp, frz);
        #1;
        check("x", o_player_x, m_x);
        check("y", o_player_y, m_y);
        check("moved", o_moved, m_moved);
        check("blocked", o_blocked, m_blk);
        check("dir", o_dir, m_dir);
        n_moves_seen  += o_moved;
        n_blocks_seen += o_blocked;
    endtask

    task automatic hold(input logic [3:0] sw, input int n);
        for (int i = 0; i < n; i++) tick(sw, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit hit;
        int pat, len;
        bit frz;
        cyc = 0;
        model_reset();
        hold(4'b0000, 3);
        RST_N = 1'b1;

        // Idle after reset
        n_moves_seen = 0;
        hold(4'b0000, 20);
        check("idle_x", o_player_x, 304);
        check("idle_y", o_player_y, 448);
        check("idle_moves", n_moves_seen, 0);

        // Short glitch is filtered, a real press steps once
        n_moves_seen = 0;
        hold(4'b0100, 3);
        hold(4'b0000, 12);
        check("glitch_moves", n_moves_seen, 0);
        hold(4'b0100, 8);
        hold(4'b0000, 15);
        check("left_moves", n_moves_seen, 1);
        check("left_x", o_player_x, 272);
        check("left_dir", o_dir, 2);

        // Long hold: autorepeat cadence
        hold(4'b0001, 40);
        hold(4'b0000, 15);

        // Up beats right; releasing up gives an immediate right step
        hold(4'b1001, 15);
        hold(4'b1000, 15);
        hold(4'b0000, 15);

        // Back to spawn, then blocked edges
        tick(4'b0000, 1'b1, 1'b0);
        hold(4'b0000, 5);
        n_blocks_seen = 0;
        hold(4'b0010, 8);
        hold(4'b0000, 12);
        check("down_blocked", n_blocks_seen, 1);
        check("down_y", o_player_y, 448);
        check("down_dir", o_dir, 1);
        for (int p = 0; p < 10; p++) begin
            hold(4'b0100, 8);
            hold(4'b0000, 10);
        end
        check("left_edge_x", o_player_x, 16);
        check("left_edge_dir", o_dir, 2);

        // Respawn in the very cycle a step would register
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            tick(4'b0001, 1'b0, 1'b0);
            hit = m_deb[0];
        end
        check("resp_sync_found", hit, 1);
        tick(4'b0001, 1'b1, 1'b0);
        check("resp_x", o_player_x, 304);
        check("resp_y", o_player_y, 448);
        check("resp_moved", o_moved, 0);
        n_moves_seen = 0;
        hold(4'b0001, 25);
        check("lockout_moves", n_moves_seen, 0);
        hold(4'b0000, 12);
        hold(4'b0001, 8);
        hold(4'b0000, 2);
        check("repress_moves", n_moves_seen, 1);
        check("repress_y", o_player_y, 416);
        hold(4'b0000, 10);

        // Asynchronous reset while repeating
        hold(4'b0001, 30);
        #2;
        RST_N = 1'b0;
        {SW4, SW3, SW2, SW1} = 4'b0000;
        #1;
        check("arst_x", o_player_x, 304);
        check("arst_y", o_player_y, 448);
        check("arst_moved", o_moved, 0);
        check("arst_blocked", o_blocked, 0);
        check("arst_dir", o_dir, 0);
        model_reset();
        hold(4'b0000, 3);
        RST_N = 1'b1;
        hold(4'b0000, 5);

        // Randomized traffic
        for (int s = 0; s < 120; s++) begin
            pat = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 15);
            len = $urandom_range(1, 30);
            frz = ($urandom_range(0, 11) == 0);
            for (int i = 0; i < len; i++)
                tick(pat[3:0], ($urandom_range(0, 59) == 0), frz);
        end
        hold(4'b0000, 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
